// File: rtl/bf16_to_mxint8.sv
// bf16_to_mxint8
//   Collects block_size bf16 elements into a single buffer, finds the shared
//   exponent, then streams the block back out as MXINT8: one E8M0 scale per
//   block plus block_size signed 8-bit elements with implicit weight 2^-6.
//   Fill and drain phases never overlap.
//
// Parameters
//   block_size : elements per block (power of two, 2..64)
//   scale_bias : E8M0 bias applied to o_scale
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_valid  : i_bf16 holds an element        o_ready : element accepted this cycle
//   i_bf16   : {sign, exp[7:0], man[6:0]}
//   o_valid  : o_scale/o_elem/o_last valid    i_ready : downstream accepts element
//   o_scale  : shared E8M0 scale of the block being drained
//   o_elem   : two's-complement MXINT8 element
//   o_last   : o_elem is the final element of its block
module bf16_to_mxint8 #(
  parameter int block_size = 32,
  parameter int scale_bias = 127
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_bf16,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_scale,
  output logic [7:0]  o_elem,
  output logic        o_last
);

  localparam int CW = (block_size > 1) ? $clog2(block_size) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(block_size - 1);

  typedef enum logic {FILL, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  // Running statistics of the block being filled.
  logic [7:0]    max_exp_q, max_exp_d;
  logic          nan_q, nan_d;
  // Statistics frozen for the block being drained, so the fill-side
  // accumulators can be cleared for the next block on the same edge.
  logic [7:0]    blk_exp_q, blk_exp_d;
  logic          blk_nan_q, blk_nan_d;
  logic          o_ready_q, o_ready_d;
  logic          o_valid_q, o_valid_d;
  logic          o_last_q, o_last_d;
  logic [7:0]    o_scale_q, o_scale_d;
  logic [7:0]    o_elem_q, o_elem_d;

  logic [15:0]   buf_mem [block_size];

  logic          in_hs, out_hs;
  logic [7:0]    exp_in, in_max;
  logic          in_nan;
  logic [CW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic [7:0]    q_mexp;
  logic          q_nan;
  logic [7:0]    q_elem;

  assign in_hs  = i_valid & o_ready_q;
  assign out_hs = o_valid_q & i_ready;

  assign exp_in = i_bf16[14:7];
  assign in_max = (exp_in > max_exp_q) ? exp_in : max_exp_q;
  assign in_nan = nan_q | (exp_in == 8'hFF);

  // Quantise one bf16 element against the block exponent.
  // sig is 1.7 fixed point; the result keeps 6 fractional bits, hence the +1
  // in the shift. ext holds the integer part in [16:9], the round bit in [8]
  // and the sticky bits below it; 9 guard bits cover every shift below 10.
  function automatic logic [7:0] quantise(input logic [15:0] x,
                                          input logic [7:0]  mexp,
                                          input logic        nan);
    logic [7:0]  e;
    logic [7:0]  sig;
    logic [8:0]  d;
    logic [16:0] ext;
    logic [7:0]  ip;
    logic        r;
    logic        s;
    logic        up;
    logic [8:0]  mag;
    logic [7:0]  m8;
    e   = x[14:7];
    sig = {(e != 8'd0), x[6:0]};
    d   = {1'b0, mexp} - {1'b0, e} + 9'd1;
    ext = {sig, 9'b0} >> d[3:0];
    ip  = ext[16:9];
    r   = ext[8];
    s   = |ext[7:0];
    up  = r & (s | ip[0]);
    mag = {1'b0, ip} + {8'b0, up};
    m8  = (mag > 9'd127) ? 8'd127 : mag[7:0];
    if (nan || (e == 8'd0) || (d >= 9'd10)) begin
      return 8'd0;
    end
    return x[15] ? (8'd0 - m8) : m8;
  endfunction

  // E8M0 scale with configurable bias, clamped to 0..254; 0xFF marks NaN/Inf.
  function automatic logic [7:0] scale_of(input logic [7:0] mexp, input logic nan);
    int s;
    s = int'(mexp) - 127 + scale_bias;
    if (nan)    return 8'hFF;
    if (s < 0)  return 8'd0;
    if (s > 254) return 8'd254;
    return s[7:0];
  endfunction

  // While filling, the only element that will be needed next is buffer[0]
  // (quantised on the final input handshake, using the exponent that already
  // includes that final element). While draining, look one element ahead.
  assign rd_addr = (state_q == FILL) ? '0 : (rd_cnt_q + CW'(1));
  assign rd_data = buf_mem[rd_addr];
  assign q_mexp  = (state_q == FILL) ? in_max : blk_exp_q;
  assign q_nan   = (state_q == FILL) ? in_nan : blk_nan_q;
  assign q_elem  = quantise(rd_data, q_mexp, q_nan);

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    max_exp_d = max_exp_q;
    nan_d     = nan_q;
    blk_exp_d = blk_exp_q;
    blk_nan_d = blk_nan_q;
    o_ready_d = o_ready_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_scale_d = o_scale_q;
    o_elem_d  = o_elem_q;
    case (state_q)
      FILL: begin
        o_ready_d = 1'b1;
        o_valid_d = 1'b0;
        if (in_hs) begin
          wr_cnt_d  = wr_cnt_q + CW'(1);
          max_exp_d = in_max;
          nan_d     = in_nan;
          if (wr_cnt_q == LAST_IDX) begin
            state_d   = DRAIN;
            wr_cnt_d  = '0;
            max_exp_d = 8'd0;
            nan_d     = 1'b0;
            blk_exp_d = in_max;
            blk_nan_d = in_nan;
            rd_cnt_d  = '0;
            o_scale_d = scale_of(in_max, in_nan);
            o_elem_d  = q_elem;
            o_last_d  = 1'b0;
            o_ready_d = 1'b0;
            o_valid_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (o_last_q) begin
            state_d   = FILL;
            rd_cnt_d  = '0;
            o_last_d  = 1'b0;
            o_valid_d = 1'b0;
            o_ready_d = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
            o_elem_d = q_elem;
            o_last_d = ((rd_cnt_q + CW'(1)) == LAST_IDX);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= FILL;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      max_exp_q <= 8'd0;
      nan_q     <= 1'b0;
      blk_exp_q <= 8'd0;
      blk_nan_q <= 1'b0;
      o_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_scale_q <= 8'd0;
      o_elem_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      max_exp_q <= max_exp_d;
      nan_q     <= nan_d;
      blk_exp_q <= blk_exp_d;
      blk_nan_q <= blk_nan_d;
      o_ready_q <= o_ready_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_scale_q <= o_scale_d;
      o_elem_q  <= o_elem_d;
    end
  end

  // Element storage carries no reset: every slot is rewritten before use.
  always_ff @(posedge i_clk) begin
    if (in_hs) begin
      buf_mem[wr_cnt_q] <= i_bf16;
    end
  end

  assign o_ready = o_ready_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_scale = o_scale_q;
  assign o_elem  = o_elem_q;

endmodule

// File: tb/tb_bf16_to_mxint8.sv
// Testbench for bf16_to_mxint8 with block_size=4, scale_bias=127.
module tb_bf16_to_mxint8;
  localparam int BS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_bf16 = 16'h0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [7:0]  o_scale;
  logic [7:0]  o_elem;
  logic        o_last;

  always #5 clk = ~clk;

  bf16_to_mxint8 #(.block_size(BS), .scale_bias(127)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_bf16(i_bf16), .o_valid(o_valid), .i_ready(i_ready),
    .o_scale(o_scale), .o_elem(o_elem), .o_last(o_last)
  );

  typedef struct packed {
    logic [7:0] scale;
    logic [7:0] elem;
    logic       last;
  } out_t;

  out_t        exp_q[$];
  out_t        obs_q[$];
  logic [15:0] blk [BS];
  int          checks = 0;
  int          failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] s, input logic [7:0] e, input logic l);
    out_t t;
    t.scale = s; t.elem = e; t.last = l;
    exp_q.push_back(t);
  endtask

  // Drive the elements of blk[] with handshakes, waiting on o_ready.
  task automatic send_block();
    for (int i = 0; i < BS; i++) begin
      int n;
      i_valid = 1'b1;
      i_bf16  = blk[i];
      n = 0;
      while (!o_ready && n < 50) begin tick(); n++; end
      if (n >= 50) begin
        checks++; failures++;
        $display("FAIL send_timeout: o_ready=%b after %0d cycles, required 1", o_ready, n);
      end
      tick();
    end
    i_valid = 1'b0;
  endtask

  // Drain one block with i_ready=1, recording each output handshake.
  task automatic collect();
    bit done = 0;
    obs_q.delete();
    i_ready = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (o_valid && i_ready) begin
        out_t t;
        t.scale = o_scale; t.elem = o_elem; t.last = o_last;
        obs_q.push_back(t);
        if (o_last) done = 1;
      end
      tick();
    end
    i_ready = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL collect_timeout: o_last handshake seen=%b, required 1", done);
    end
  endtask

  // Model of one element: integer division with round-half-even.
  function automatic logic [7:0] model_elem(input logic [15:0] x, input int mexp, input bit nan);
    int e, sig, d, dv, q, rem;
    e = int'(x[14:7]);
    if (nan || e == 0) return 8'h00;
    sig = 128 + int'(x[6:0]);
    d = mexp - e + 1;
    if (d >= 10) return 8'h00;
    dv = 1 << d;
    q = sig / dv;
    rem = sig % dv;
    if (2 * rem > dv || (2 * rem == dv && (q % 2) == 1)) q++;
    if (q > 127) q = 127;
    return x[15] ? 8'(-q) : 8'(q);
  endfunction

  function automatic logic [7:0] model_scale(input int mexp, input bit nan);
    int s;
    if (nan) return 8'hFF;
    s = mexp - 127 + 127;
    if (s < 0) s = 0;
    if (s > 254) s = 254;
    return 8'(s);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({o_valid, o_ready, o_last, o_scale, o_elem} !== 19'd0) begin
      failures++;
      $display("FAIL reset_state: got v=%b r=%b l=%b s=%h e=%h, required all 0",
               o_valid, o_ready, o_last, o_scale, o_elem);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_pre_edge: got %b, required 0", o_ready);
    end
    tick();
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise: got %b, required 1", o_ready);
    end
    $display("reset: v=%b r=%b scale=%h elem=%h", o_valid, o_ready, o_scale, o_elem);
  endtask

  task automatic test_basic();
    blk[0] = 16'h3F80; blk[1] = 16'h4000; blk[2] = 16'hBF00; blk[3] = 16'h0000;
    push_exp(8'h80, 8'h20, 0); push_exp(8'h80, 8'h40, 0);
    push_exp(8'h80, 8'hF0, 0); push_exp(8'h80, 8'h00, 1);
    send_block();
    checks++;
    if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency: got v=%b r=%b one cycle after last input, required v=1 r=0",
               o_valid, o_ready);
    end
    collect();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_return_fill: got r=%b v=%b, required r=1 v=0", o_ready, o_valid);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("FAIL basic[%0d]: got no output, required scale=%h elem=%h", i, e.scale, e.elem);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL basic[%0d]: got s=%h e=%h l=%b, required s=%h e=%h l=%b",
                   i, o.scale, o.elem, o.last, e.scale, e.elem, e.last);
        end else $display("basic[%0d]: scale=%h elem=%h last=%b", i, o.scale, o.elem, o.last);
      end
    end
  endtask

  task automatic test_saturation();
    blk[0] = 16'h3FFF; blk[1] = 16'h3F80; blk[2] = 16'h3F80; blk[3] = 16'h3F80;
    push_exp(8'h7F, 8'h7F, 0); push_exp(8'h7F, 8'h40, 0);
    push_exp(8'h7F, 8'h40, 0); push_exp(8'h7F, 8'h40, 1);
    send_block();
    collect();
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front();
      checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      if (o !== e) begin
        failures++;
        $display("FAIL saturation[%0d]: got s=%h e=%h l=%b, required s=%h e=%h l=%b",
                 i, o.scale, o.elem, o.last, e.scale, e.elem, e.last);
      end else $display("saturation[%0d]: scale=%h elem=%h last=%b", i, o.scale, o.elem, o.last);
    end
  endtask

  task automatic test_rounding();
    blk[0] = 16'h3F80; blk[1] = 16'h3C00; blk[2] = 16'h3C40; blk[3] = 16'hBC40;
    push_exp(8'h7F, 8'h40, 0); push_exp(8'h7F, 8'h00, 0);
    push_exp(8'h7F, 8'h01, 0); push_exp(8'h7F, 8'hFF, 1);
    send_block();
    collect();
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front();
      checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      if (o !== e) begin
        failures++;
        $display("FAIL rounding[%0d]: got s=%h e=%h l=%b, required s=%h e=%h l=%b",
                 i, o.scale, o.elem, o.last, e.scale, e.elem, e.last);
      end else $display("rounding[%0d]: scale=%h elem=%h last=%b", i, o.scale, o.elem, o.last);
    end
  endtask

  task automatic test_special();
    // Inf block followed by an all-zero block.
    blk[0] = 16'h7F80; blk[1] = 16'h3F80; blk[2] = 16'h3F80; blk[3] = 16'h3F80;
    for (int i = 0; i < BS; i++) push_exp(8'hFF, 8'h00, i == BS - 1);
    send_block();
    collect();
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front();
      checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      if (o !== e) begin
        failures++;
        $display("FAIL special_nan[%0d]: got s=%h e=%h l=%b, required s=%h e=%h l=%b",
                 i, o.scale, o.elem, o.last, e.scale, e.elem, e.last);
      end else $display("special_nan[%0d]: scale=%h elem=%h last=%b", i, o.scale, o.elem, o.last);
    end
    for (int i = 0; i < BS; i++) blk[i] = 16'h0000;
    for (int i = 0; i < BS; i++) push_exp(8'h00, 8'h00, i == BS - 1);
    send_block();
    collect();
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front();
      checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      if (o !== e) begin
        failures++;
        $display("FAIL special_zero[%0d]: got s=%h e=%h l=%b, required s=%h e=%h l=%b",
                 i, o.scale, o.elem, o.last, e.scale, e.elem, e.last);
      end else $display("special_zero[%0d]: scale=%h elem=%h last=%b", i, o.scale, o.elem, o.last);
    end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    out_t prev;
    bit   prev_stall = 0;
    bit   done = 0;
    int   k = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    blk[0] = 16'h3F80; blk[1] = 16'h4000; blk[2] = 16'hBF00; blk[3] = 16'h0000;
    push_exp(8'h80, 8'h20, 0); push_exp(8'h80, 8'h40, 0);
    push_exp(8'h80, 8'hF0, 0); push_exp(8'h80, 8'h00, 1);
    send_block();
    for (int n = 0; n < 60 && !done; n++) begin
      out_t cur;
      i_ready = pat[k % 4];
      k++;
      cur.scale = o_scale; cur.elem = o_elem; cur.last = o_last;
      if (prev_stall) begin
        checks++;
        if (cur !== prev || o_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_stable: got v=%b s=%h e=%h l=%b, required v=1 s=%h e=%h l=%b",
                   o_valid, cur.scale, cur.elem, cur.last, prev.scale, prev.elem, prev.last);
        end
      end
      if (o_valid) begin
        checks++;
        if (o_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_ready_low: got o_ready=%b during drain, required 0", o_ready);
        end
      end
      if (o_valid && i_ready) begin
        out_t e;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        if (cur !== e) begin
          failures++;
          $display("FAIL bp_elem: got s=%h e=%h l=%b, required s=%h e=%h l=%b",
                   cur.scale, cur.elem, cur.last, e.scale, e.elem, e.last);
        end else $display("backpressure: scale=%h elem=%h last=%b", cur.scale, cur.elem, cur.last);
        if (o_last) done = 1;
      end
      prev_stall = o_valid && !i_ready;
      prev = cur;
      tick();
    end
    i_ready = 1'b0;
    checks++;
    if (!done || exp_q.size() != 0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_complete: got done=%b left=%0d r=%b, required done=1 left=0 r=1",
               done, exp_q.size(), o_ready);
    end
  endtask

  task automatic test_mid_reset();
    // Partial block with a large exponent, then reset mid-fill.
    i_valid = 1'b1; i_bf16 = 16'h4300;
    tick(); tick();
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_fill_async: got v=%b r=%b, required v=0 r=0", o_valid, o_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    blk[0] = 16'h3F80; blk[1] = 16'h4000; blk[2] = 16'hBF00; blk[3] = 16'h0000;
    push_exp(8'h80, 8'h20, 0); push_exp(8'h80, 8'h40, 0);
    push_exp(8'h80, 8'hF0, 0); push_exp(8'h80, 8'h00, 1);
    send_block();
    collect();
    for (int i = 0; exp_q.size() > 0; i++) begin
      out_t e, o;
      e = exp_q.pop_front();
      checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      if (o !== e) begin
        failures++;
        $display("FAIL rst_fresh[%0d]: got s=%h e=%h l=%b, required s=%h e=%h l=%b",
                 i, o.scale, o.elem, o.last, e.scale, e.elem, e.last);
      end else $display("rst_fresh[%0d]: scale=%h elem=%h last=%b", i, o.scale, o.elem, o.last);
    end
    // Reset mid-drain: no further output of that block may appear.
    send_block();
    i_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_drain_async: got v=%b, required 0", o_valid);
    end
    tick();
    rst_n = 1'b1;
    begin
      bit seen = 0;
      for (int n = 0; n < 4; n++) begin
        tick();
        if (o_valid) seen = 1;
      end
      checks++;
      if (seen) begin
        failures++;
        $display("FAIL rst_drain_discard: got stale o_valid=1, required 0");
      end
    end
    i_ready = 1'b0;
    $display("mid_reset: v=%b r=%b", o_valid, o_ready);
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      int  mexp = 0;
      bit  nan = 0;
      for (int i = 0; i < BS; i++) begin
        logic [7:0] e;
        e = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(110, 135));
        blk[i] = {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
        if (int'(e) > mexp) mexp = int'(e);
        if (e == 8'hFF) nan = 1;
      end
      for (int i = 0; i < BS; i++)
        push_exp(model_scale(mexp, nan), model_elem(blk[i], mexp, nan), i == BS - 1);
      send_block();
      collect();
      for (int i = 0; exp_q.size() > 0; i++) begin
        out_t e, o;
        e = exp_q.pop_front();
        checks++;
        o = (obs_q.size() > 0) ? obs_q.pop_front() : {8'h00, 8'h00, ~e.last};
        if (o !== e) begin
          failures++;
          $display("FAIL b2b[%0d][%0d] in=%h: got s=%h e=%h l=%b, required s=%h e=%h l=%b",
                   b, i, blk[i], o.scale, o.elem, o.last, e.scale, e.elem, e.last);
        end else $display("b2b[%0d][%0d]: in=%h scale=%h elem=%h last=%b",
                          b, i, blk[i], o.scale, o.elem, o.last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_special();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
